// File: rtl/dii_fetch_sched.sv
// DII fetch scheduler: routes fetches to one of two generators by PC decode and tracks grants
// in an in-order queue checked against retirement. Optional macro DII_SRC_STATS_EN adds grant counters.
module dii_fetch_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] SRC1_BASE = 32'h8000_0000,
  parameter logic [31:0] SRC1_MASK = 32'hF000_0000,
  parameter int unsigned MAX_FLUSH = 1,
  localparam int unsigned PtrW     = $clog2(DEPTH),
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_req_i,
  input  logic [31:0]     fetch_pc_i,
  output logic            fetch_gnt_o,
  output logic [31:0]     fetch_insn_o,
  input  logic [31:0]     dii_insn_0_i,
  input  logic            dii_rdy_0_i,
  output logic            dii_ack_0_o,
  input  logic [31:0]     dii_insn_1_i,
  input  logic            dii_rdy_1_i,
  output logic            dii_ack_1_o,
  output logic [31:0]     dii_pc_o,
  input  logic            retire_valid_i,
  input  logic            retire_trap_i,
  input  logic [31:0]     retire_pc_i,
  input  logic [31:0]     retire_insn_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic [31:0]     fetch_cnt0_o,
  output logic [31:0]     fetch_cnt1_o
);

  typedef enum logic [0:0] {StNorm, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q   [DEPTH];
  logic [31:0]     insn_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_after, pop_cnt;
  logic            err_q, err_set;
  logic [1:0]      code_q, err_new;
  logic            sel1, src_rdy, found;
  int unsigned     k;

  function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] p, int unsigned n);
    int unsigned s;
    s = int'(p) + n;
    return PtrW'(s % DEPTH);
  endfunction

  assign sel1         = (fetch_pc_i & SRC1_MASK) == SRC1_BASE;
  assign src_rdy      = sel1 ? dii_rdy_1_i : dii_rdy_0_i;
  assign fetch_insn_o = sel1 ? dii_insn_1_i : dii_insn_0_i;
  assign dii_pc_o     = fetch_pc_i;

  always_comb begin
    pop_cnt = '0;
    state_d = state_q;
    err_set = 1'b0;
    err_new = 2'b00;
    found   = 1'b0;
    k       = 0;
    if (retire_valid_i) begin
      unique case (state_q)
        StNorm: begin
          if (count_q == '0) begin
            err_set = 1'b1;
            err_new = 2'b01;
          end else begin
            pop_cnt = CntW'(1);
            if (pc_q[head_q] != retire_pc_i || insn_q[head_q] != retire_insn_i) begin
              err_set = 1'b1;
              err_new = 2'b10;
            end
          end
          if (retire_trap_i) state_d = StFlush;
        end
        StFlush: begin
          // Oldest matching entry wins; everything ahead of it is stale.
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && i < int'(count_q) &&
                pc_q[wrap_add(head_q, i)] == retire_pc_i &&
                insn_q[wrap_add(head_q, i)] == retire_insn_i) begin
              found = 1'b1;
              k     = i;
            end
          end
          if (found && k <= MAX_FLUSH) begin
            pop_cnt = CntW'(k + 1);
          end else begin
            err_set = 1'b1;
            err_new = 2'b11;
            pop_cnt = count_q;
          end
          state_d = retire_trap_i ? StFlush : StNorm;
        end
        default: state_d = StNorm;
      endcase
    end
  end

  // Grant sees the post-pop occupancy so a full queue can accept while retiring.
  assign count_after = count_q - pop_cnt;
  assign fetch_gnt_o = fetch_req_i & src_rdy & (int'(count_after) < DEPTH);
  assign dii_ack_0_o = fetch_gnt_o & ~sel1;
  assign dii_ack_1_o = fetch_gnt_o & sel1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StNorm;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        insn_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= wrap_add(head_q, int'(pop_cnt));
      count_q <= count_after + CntW'(fetch_gnt_o);
      if (fetch_gnt_o) begin
        pc_q[tail_q]   <= fetch_pc_i;
        insn_q[tail_q] <= fetch_insn_o;
        tail_q         <= wrap_add(tail_q, 1);
      end
      if (err_set && !err_q) code_q <= err_new;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;

`ifdef DII_SRC_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (dii_ack_0_o) cnt0_q <= cnt0_q + 32'd1;
      if (dii_ack_1_o) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign fetch_cnt0_o = cnt0_q;
  assign fetch_cnt1_o = cnt1_q;
`else
  assign fetch_cnt0_o = 32'h0;
  assign fetch_cnt1_o = 32'h0;
`endif

endmodule

// File: tb/tb_dii_fetch_sched.sv
// Directed self-checking bench for dii_fetch_sched with hand-computed expectations.
module tb_dii_fetch_sched;

`ifdef DII_SRC_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_req_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_gnt_o;
  logic [31:0] fetch_insn_o;
  logic [31:0] dii_insn_0_i, dii_insn_1_i;
  logic        dii_rdy_0_i, dii_rdy_1_i;
  logic        dii_ack_0_o, dii_ack_1_o;
  logic [31:0] dii_pc_o;
  logic        retire_valid_i, retire_trap_i;
  logic [31:0] retire_pc_i, retire_insn_i;
  logic [2:0]  outstanding_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [31:0] fetch_cnt0_o, fetch_cnt1_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  dii_fetch_sched dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_req_i    (fetch_req_i),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_insn_o   (fetch_insn_o),
    .dii_insn_0_i   (dii_insn_0_i),
    .dii_rdy_0_i    (dii_rdy_0_i),
    .dii_ack_0_o    (dii_ack_0_o),
    .dii_insn_1_i   (dii_insn_1_i),
    .dii_rdy_1_i    (dii_rdy_1_i),
    .dii_ack_1_o    (dii_ack_1_o),
    .dii_pc_o       (dii_pc_o),
    .retire_valid_i (retire_valid_i),
    .retire_trap_i  (retire_trap_i),
    .retire_pc_i    (retire_pc_i),
    .retire_insn_i  (retire_insn_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .fetch_cnt0_o   (fetch_cnt0_o),
    .fetch_cnt1_o   (fetch_cnt1_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    fetch_req_i    = 1'b0;
    fetch_pc_i     = '0;
    dii_insn_0_i   = '0;
    dii_insn_1_i   = '0;
    dii_rdy_0_i    = 1'b0;
    dii_rdy_1_i    = 1'b0;
    retire_valid_i = 1'b0;
    retire_trap_i  = 1'b0;
    retire_pc_i    = '0;
    retire_insn_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic [31:0] insn);
    fetch_req_i  = 1'b1;
    fetch_pc_i   = pc;
    dii_insn_0_i = insn;
    dii_insn_1_i = insn;
    dii_rdy_0_i  = 1'b1;
    dii_rdy_1_i  = 1'b1;
  endtask

  task automatic set_retire(input logic [31:0] pc, input logic [31:0] insn, input logic trap);
    retire_valid_i = 1'b1;
    retire_trap_i  = trap;
    retire_pc_i    = pc;
    retire_insn_i  = insn;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1 idle();
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insn);
    @(negedge clk_i);
    set_fetch(pc, insn);
    #1 chk("push_gnt", 32'(fetch_gnt_o), 32'd1);
    step();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic trap);
    @(negedge clk_i);
    set_retire(pc, insn, trap);
    step();
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    #12;
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_gnt", 32'(fetch_gnt_o), 32'd0);
    rst_ni = 1'b1;

    // 1: source 0 fetch
    @(negedge clk_i);
    fetch_req_i  = 1'b1;
    fetch_pc_i   = 32'h100;
    dii_rdy_0_i  = 1'b1;
    dii_insn_0_i = 32'hAAAA_0001;
    dii_insn_1_i = 32'h5555_0001;
    #1;
    chk("t1_gnt", 32'(fetch_gnt_o), 32'd1);
    chk("t1_ack0", 32'(dii_ack_0_o), 32'd1);
    chk("t1_ack1", 32'(dii_ack_1_o), 32'd0);
    chk("t1_insn", fetch_insn_o, 32'hAAAA_0001);
    chk("t1_pc", dii_pc_o, 32'h100);
    step();
    chk("t1_out", 32'(outstanding_o), 32'd1);

    // 2: source 1 fetch, then retire both
    @(negedge clk_i);
    fetch_req_i  = 1'b1;
    fetch_pc_i   = 32'h8000_0010;
    dii_rdy_1_i  = 1'b1;
    dii_insn_1_i = 32'h0000_0013;
    dii_insn_0_i = 32'hDEAD_BEEF;
    #1;
    chk("t2_ack1", 32'(dii_ack_1_o), 32'd1);
    chk("t2_ack0", 32'(dii_ack_0_o), 32'd0);
    chk("t2_insn", fetch_insn_o, 32'h13);
    step();
    chk("t2_out", 32'(outstanding_o), 32'd2);
    retire(32'h100, 32'hAAAA_0001, 1'b0);
    retire(32'h8000_0010, 32'h13, 1'b0);
    chk("t2_out_after", 32'(outstanding_o), 32'd0);
    chk("t2_err", 32'(err_o), 32'd0);

    // 3: fill, blocked 5th, retire+fetch on full queue
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
    chk("t3_full", 32'(outstanding_o), 32'd4);
    @(negedge clk_i);
    set_fetch(32'h210, 32'h1004);
    #1;
    chk("t3_full_gnt", 32'(fetch_gnt_o), 32'd0);
    chk("t3_full_ack", 32'(dii_ack_0_o), 32'd0);
    set_retire(32'h200, 32'h1000, 1'b0);
    #1 chk("t3_pop_gnt", 32'(fetch_gnt_o), 32'd1);
    step();
    chk("t3_out_same", 32'(outstanding_o), 32'd4);
    for (int i = 1; i < 5; i++) retire(32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    chk("t3_drained", 32'(outstanding_o), 32'd0);
    chk("t3_err", 32'(err_o), 32'd0);
    chk("t3_cnt0", fetch_cnt0_o, StatsEn ? 32'd6 : 32'd0);
    chk("t3_cnt1", fetch_cnt1_o, StatsEn ? 32'd1 : 32'd0);

    // 4: empty retire, then mismatch keeps first code
    retire(32'h999, 32'h999, 1'b0);
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_code", 32'(err_code_o), 32'd1);
    push(32'h240, 32'h2000);
    retire(32'h240, 32'h2001, 1'b0);
    chk("t4_code_keep", 32'(err_code_o), 32'd1);
    chk("t4_out", 32'(outstanding_o), 32'd0);

    // 5: trap flush with k=1
    do_reset();
    chk("t5_rst_err", 32'(err_o), 32'd0);
    push(32'h300, 32'h3000);
    push(32'h304, 32'h3001);
    push(32'h308, 32'h3002);
    retire(32'h300, 32'h3000, 1'b1);
    chk("t5_out_trap", 32'(outstanding_o), 32'd2);
    retire(32'h308, 32'h3002, 1'b0);
    chk("t5_out", 32'(outstanding_o), 32'd0);
    chk("t5_err", 32'(err_o), 32'd0);
    retire(32'h30C, 32'h3003, 1'b0);
    chk("t5_norm_code", 32'(err_code_o), 32'd1);

    // 6: flush too deep, then async reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'h4000 + 32'(i));
    retire(32'h400, 32'h4000, 1'b1);
    chk("t6_out_trap", 32'(outstanding_o), 32'd3);
    retire(32'h40C, 32'h4003, 1'b0);
    chk("t6_err", 32'(err_o), 32'd1);
    chk("t6_code", 32'(err_code_o), 32'd3);
    chk("t6_out", 32'(outstanding_o), 32'd0);
    push(32'h8000_0400, 32'h4100);
    chk("t6_out_push", 32'(outstanding_o), 32'd1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_out", 32'(outstanding_o), 32'd0);
    chk("t6_rst_err", 32'(err_o), 32'd0);
    chk("t6_rst_code", 32'(err_code_o), 32'd0);
    chk("t6_rst_cnt0", fetch_cnt0_o, 32'd0);
    chk("t6_rst_cnt1", fetch_cnt1_o, 32'd0);
    rst_ni = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
